// File: rtl/prev_prime_finder.sv
// Finds the largest prime strictly below num_in.
// Divisibility is tested by trial division, using one subtraction per cycle.
module prev_prime_finder #(
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] num_in,
  output logic [WIDTH-1:0] prime_out,
  output logic             found,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CAND, DIV, RESULT} state_t;

  state_t           state;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] div;
  logic [WIDTH-1:0] rem;
  logic [PW-1:0]    div_sq_c;
  logic             div_over_c;

  // The square is formed at double width, so a large divisor cannot wrap.
  assign div_sq_c   = PW'(div) * PW'(div);
  assign div_over_c = div_sq_c > PW'(cand);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= '0;
      div       <= '0;
      rem       <= '0;
      prime_out <= '0;
      found     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // A bound of 2 or less has no prime below it. Forcing cand to 0
            // also keeps num_in = 0 from wrapping to all-ones.
            cand  <= (num_in <= WIDTH'(2)) ? '0 : num_in - WIDTH'(1);
            busy  <= 1'b1;
            state <= CAND;
          end
        end
        CAND: begin
          if (cand < WIDTH'(2)) begin
            prime_out <= '0;
            found     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= RESULT;
          end else begin
            div   <= WIDTH'(2);
            rem   <= cand;
            state <= DIV;
          end
        end
        DIV: begin
          if (div_over_c) begin
            prime_out <= cand;
            found     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= RESULT;
          end else if (rem >= div) begin
            rem <= rem - div;
          end else if (rem == '0) begin
            cand  <= cand - WIDTH'(1);
            state <= CAND;
          end else begin
            div <= div + WIDTH'(1);
            rem <= cand;
          end
        end
        RESULT: begin
          // A start that arrives in this cycle is ignored.
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
